// File: rtl/demux_pkg.sv
// Shared widths and select-index helper for the gate-level 1-to-4 demux.
package demux_pkg;

  localparam int SEL_W = 2;
  localparam int OUT_W = 2 ** SEL_W;

  function automatic logic [SEL_W-1:0] sel_idx(input logic b, input logic a);
    return {b, a};
  endfunction

endpackage

// File: rtl/demux_glv_reg_if.sv
// Select/enable inputs and one-hot strobe outputs of the demux.
interface demux_glv_reg_if;
  import demux_pkg::*;

  logic             a;
  logic             b;
  logic             en;
  logic [OUT_W-1:0] z;

  modport master (output a, output b, output en, input z);
  modport slave  (input a, input b, input en, output z);

endinterface

// File: rtl/demux_glv_dec.sv
// Gate-level 2-to-4 decoder: d[{b,a}] = en, all other lines low.
// Latency: combinational; no backpressure.
module demux_glv_dec
  import demux_pkg::*;
(
  input  wire             a,
  input  wire             b,
  input  wire             en,
  output wire [OUT_W-1:0] d
);

  wire a_n;
  wire b_n;

  not u_not_a (a_n, a);
  not u_not_b (b_n, b);

  and u_and_0 (d[0], en, b_n, a_n);
  and u_and_1 (d[1], en, b_n, a);
  and u_and_2 (d[2], en, b,   a_n);
  and u_and_3 (d[3], en, b,   a);

endmodule

// File: rtl/demux_glv_reg.sv
// Registered 1-to-4 demux routing en onto line {b,a}; one-hot or all-zero z.
// Latency: 1 cycle with OUT_REG=1, 0 otherwise; no backpressure.
module demux_glv_reg
  import demux_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  demux_glv_reg_if.slave  io
);

  logic [OUT_W-1:0] d;

  demux_glv_dec u_dec (
    .a  (io.a),
    .b  (io.b),
    .en (io.en),
    .d  (d)
  );

  generate
    if (OUT_REG) begin : g_reg
      // Flop stage hides decoder hazards while a/b settle.
      always_ff @(posedge clk) begin
        if (rst) begin
          io.z <= '0;
        end else begin
          io.z <= d;
        end
      end
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign io.z = d;
    end
  endgenerate

endmodule

// File: tb/tb_demux_glv_reg.sv
// Directed bench for demux_glv_reg: registered build plus a combinational build.
module tb_demux_glv_reg;
  import demux_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  demux_glv_reg_if ifr ();
  demux_glv_reg_if ifc ();

  demux_glv_reg #(.OUT_REG(1'b1)) u_dut_reg (
    .clk (clk),
    .rst (rst),
    .io  (ifr.slave)
  );

  demux_glv_reg #(.OUT_REG(1'b0)) u_dut_comb (
    .clk (clk),
    .rst (rst),
    .io  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  bit run_mon;
  always @(negedge clk) begin
    if (run_mon) begin
      chk("onehot0", {3'b000, $onehot0(ifr.z)}, 4'b0001);
    end
  end

  logic [OUT_W-1:0] walk_exp [8];
  logic [OUT_W-1:0] sweep_exp [4];
  logic [2:0]       v;

  initial begin
    n_checks = 0;
    n_errors = 0;
    run_mon  = 1'b0;
    walk_exp  = '{4'b0000, 4'b0001, 4'b0000, 4'b0010,
                  4'b0000, 4'b0100, 4'b0000, 4'b1000};
    sweep_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    ifc.a = 1'b0; ifc.b = 1'b0; ifc.en = 1'b0;

    // Reset wins over an active enable
    rst = 1'b1; ifr.en = 1'b1; ifr.b = 1'b1; ifr.a = 1'b1;
    @(posedge clk); #1;
    chk("reset_first", ifr.z, 4'b0000);
    run_mon = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_hold", ifr.z, 4'b0000);
    end

    rst = 1'b0; ifr.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = 3'(i);
      {ifr.b, ifr.a} = v[1:0];
      @(posedge clk); #1;
      chk("en_off_sweep", ifr.z, 4'b0000);
    end

    ifr.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v = 3'(i);
      {ifr.b, ifr.a} = v[1:0];
      #2;
      chk("en_on_latency", ifr.z, (i == 0) ? 4'b0000 : sweep_exp[i-1]);
      @(posedge clk); #1;
      chk("en_on_sweep", ifr.z, sweep_exp[i]);
    end

    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {ifr.b, ifr.a, ifr.en} = v;
      @(posedge clk); #1;
      chk("walk_reg", ifr.z, walk_exp[i]);
    end

    ifr.en = 1'b1; ifr.b = 1'b1; ifr.a = 1'b0;
    @(posedge clk); #1;
    chk("midrun_pre", ifr.z, 4'b0100);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrun_rst", ifr.z, 4'b0000);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrun_release", ifr.z, 4'b0100);

    // Combinational build: output follows inputs without a clock edge
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {ifc.b, ifc.a, ifc.en} = v;
      #1;
      chk("walk_comb", ifc.z, walk_exp[i]);
    end

    run_mon = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
